tile_map_writer: RTL

- Write port for the packed tile-index RAM that the MTL display path reads.
- Tile indices are 8-bit and stored 4 per 32-bit word; byte lane = linear index [1:0]. Linear index = x + y*TILES_PER_LINE.
- Accepts tile-update commands over a valid/ready handshake and performs word-granular read-modify-write, since the RAM has no byte enables.
- Also supports a whole-map fill command and optional end-of-frame synchronisation to avoid tearing.

---
 rtl/tile_map_writer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tile_map_writer.sv
// Tile-index RAM write port for the MTL display path.
// Single-tile updates do a read-modify-write of one 32-bit word, since the RAM
// has no byte enables. Fill rewrites every word. Either command can be held
// until the next end-of-frame pulse so the update does not tear.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a command
// WAIT_SYNC | command latched, waiting for an i_end_frame pulse
// READ      | read strobe on the bus for the target word
// READ_WAIT | read data arrives; merge the tile into its byte lane
// WRITE     | write strobe with the merged word
// FILL      | one full-word write per cycle across the whole map
module tile_map_writer #(
  parameter int TILES_PER_LINE = 100,
  parameter int TILE_LINES     = 60,
  parameter int MEM_ADDR_WIDTH = 30,
  parameter int TILE_IDX_BASE  = 0
) (
  input  logic                      display_clock,
  input  logic                      reset,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_op,
  input  logic                      i_cmd_sync,
  input  logic [6:0]                i_cmd_x,
  input  logic [5:0]                i_cmd_y,
  input  logic [7:0]                i_cmd_tile,
  input  logic                      i_end_frame,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_read,
  input  logic [31:0]               i_mem_readdata,
  output logic                      o_mem_write,
  output logic [31:0]               o_mem_writedata,
  output logic                      o_busy,
  output logic [7:0]                o_drop_count
);

  localparam int FILL_WORDS = (TILES_PER_LINE * TILE_LINES + 3) / 4;
  localparam int CNT_W      = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam logic [CNT_W-1:0]          FILL_LAST = CNT_W'(FILL_WORDS - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(TILE_IDX_BASE);

  typedef enum logic [2:0] {
    IDLE, WAIT_SYNC, READ, READ_WAIT, WRITE, FILL
  } state_t;

  state_t state, state_next;

  logic             cmd_op;
  logic [7:0]       cmd_tile;
  logic [10:0]      cmd_word;
  logic [1:0]       cmd_lane;
  logic [CNT_W-1:0] fill_cnt;

  logic [12:0] lin_in;
  logic        in_range;
  logic        xfer;
  logic        drop;
  logic [10:0] word_src;
  logic [7:0]  tile_src;
  logic [31:0] merged;

  assign lin_in   = 13'(i_cmd_y) * 13'(TILES_PER_LINE) + 13'(i_cmd_x);
  assign in_range = (int'(i_cmd_x) < TILES_PER_LINE) && (int'(i_cmd_y) < TILE_LINES);
  assign xfer     = i_cmd_valid && (state == IDLE);
  assign drop     = xfer && !i_cmd_op && !in_range;

  // Leaving IDLE directly, the latched fields are not loaded yet; use the inputs.
  assign word_src = (state == IDLE) ? lin_in[12:2] : cmd_word;
  assign tile_src = (state == IDLE) ? i_cmd_tile : cmd_tile;

  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer && !drop) begin
          if (i_cmd_sync)    state_next = WAIT_SYNC;
          else if (i_cmd_op) state_next = FILL;
          else               state_next = READ;
        end
      end
      WAIT_SYNC: if (i_end_frame) state_next = cmd_op ? FILL : READ;
      READ:      state_next = READ_WAIT;
      READ_WAIT: state_next = WRITE;
      WRITE:     state_next = IDLE;
      FILL:      if (fill_cnt == FILL_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Replace the addressed byte lane of the returned word with the new tile.
  always_comb begin
    merged = i_mem_readdata;
    merged[{cmd_lane, 3'b000} +: 8] = cmd_tile;
  end

  // State register and command capture at transfer.
  always_ff @(posedge display_clock) begin
    if (!reset) begin
      state    <= IDLE;
      cmd_op   <= 1'b0;
      cmd_tile <= 8'd0;
      cmd_word <= 11'd0;
      cmd_lane <= 2'd0;
    end else begin
      state <= state_next;
      if (xfer && !drop) begin
        cmd_op   <= i_cmd_op;
        cmd_tile <= i_cmd_tile;
        cmd_word <= lin_in[12:2];
        cmd_lane <= lin_in[1:0];
      end
    end
  end

  // Saturating count of out-of-range single-tile commands.
  always_ff @(posedge display_clock) begin
    if (!reset) begin
      o_drop_count <= 8'd0;
    end else if (drop && (o_drop_count != 8'hFF)) begin
      o_drop_count <= o_drop_count + 8'd1;
    end
  end

  // Registered memory bus: strobes follow the state being entered; address and data hold otherwise.
  always_ff @(posedge display_clock) begin
    if (!reset) begin
      o_mem_read      <= 1'b0;
      o_mem_write     <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_writedata <= 32'd0;
      fill_cnt        <= '0;
    end else begin
      o_mem_read  <= (state_next == READ);
      o_mem_write <= (state_next == WRITE) || (state_next == FILL);
      if (state_next == READ) begin
        o_mem_addr <= BASE_ADDR + MEM_ADDR_WIDTH'(word_src);
      end else if (state_next == WRITE) begin
        o_mem_writedata <= merged;
      end else if (state_next == FILL) begin
        if (state != FILL) begin
          o_mem_addr      <= BASE_ADDR;
          o_mem_writedata <= {4{tile_src}};
          fill_cnt        <= '0;
        end else begin
          o_mem_addr <= o_mem_addr + MEM_ADDR_WIDTH'(1);
          fill_cnt   <= fill_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
